// File: rtl/fpu_ret_merge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_ret_merge_if : merged retire output handshake (valid/ready bus)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fpu_ret_merge_if;
  logic        rt_valid;
  logic        rt_ready;
  logic [13:0] rt_data;
  logic [1:0]  rt_port;

  modport master (output rt_valid, output rt_data, output rt_port, input rt_ready);
  modport slave  (input rt_valid, input rt_data, input rt_port, output rt_ready);
endinterface
`default_nettype wire

// File: rtl/fpu_ret_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_ret_merge : three per-port retire FIFOs merged round-robin onto  |
// | one valid/ready bus. Define FPU_RET_STICKY_EN for sticky flags.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fpu_ret_merge #(
  parameter int DEPTH     = 4,
  parameter int STALL_LVL = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [13:0] u1_ret,
  input  wire logic [13:0] u3_ret,
  input  wire logic [13:0] u5_ret,
  input  wire logic        u1_ret_en,
  input  wire logic        u3_ret_en,
  input  wire logic        u5_ret_en,
  output logic             u1_stall,
  output logic             u3_stall,
  output logic             u5_stall,
  fpu_ret_merge_if.master  rt,
  output logic [4:0]       sticky_flags,
  input  wire logic        flag_clr,
  output logic             ovf_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [13:0] ret_in [3];
  logic [2:0]  ret_en;
  logic [13:0] head [3];
  logic [2:0]  nonempty;
  logic [2:0]  drop_vec;
  logic [2:0]  stall_vec;
  logic [2:0]  pop_vec;
  logic        pop;
  logic [1:0]  gnt;
  logic [13:0] head_sel;

  logic [1:0] prio_q, prio_d;
  logic [1:0] gnt_hold_q, gnt_hold_d;
  logic       lock_q, lock_d;
  logic       ovf_q, ovf_d;

  assign ret_in[0] = u1_ret;
  assign ret_in[1] = u3_ret;
  assign ret_in[2] = u5_ret;
  assign ret_en    = {u5_ret_en, u3_ret_en, u1_ret_en};

  for (genvar p = 0; p < 3; p++) begin : g_fifo
    logic [13:0]   mem_q [DEPTH];
    logic [13:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic          full, wr;

    always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      // A full FIFO still accepts a write when its head leaves this cycle.
      wr       = ret_en[p] && (!full || pop_vec[p]);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr) begin
        mem_d[wr_ptr_q] = ret_in[p];
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_vec[p]) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr, pop_vec[p]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      stall_d = (cnt_d >= CW'(STALL_LVL));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        stall_q  <= 1'b0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        stall_q  <= stall_d;
      end
    end

    assign head[p]      = mem_q[rd_ptr_q];
    assign nonempty[p]  = (cnt_q != '0);
    assign drop_vec[p]  = ret_en[p] && full && !pop_vec[p];
    assign stall_vec[p] = stall_q;
  end

  always_comb begin
    gnt = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (nonempty[2'((int'(prio_q) + i) % 3)]) gnt = 2'((int'(prio_q) + i) % 3);
    end
    // Keep the presented word stable while the consumer is stalling.
    if (lock_q) gnt = gnt_hold_q;

    case (gnt)
      2'd1:    head_sel = head[1];
      2'd2:    head_sel = head[2];
      default: head_sel = head[0];
    endcase

    rt.rt_valid = |nonempty;
    rt.rt_data  = rt.rt_valid ? head_sel : 14'd0;
    rt.rt_port  = rt.rt_valid ? gnt : 2'd0;
    pop         = rt.rt_valid && rt.rt_ready;
    pop_vec     = pop ? (3'b001 << gnt) : 3'b000;

    lock_d      = rt.rt_valid && !rt.rt_ready;
    gnt_hold_d  = gnt;
    prio_d      = prio_q;
    if (pop) prio_d = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
    ovf_d       = ovf_q | (|drop_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 2'd0;
      gnt_hold_q <= 2'd0;
      lock_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      gnt_hold_q <= gnt_hold_d;
      lock_q     <= lock_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf_err  = ovf_q;
  assign u1_stall = stall_vec[0];
  assign u3_stall = stall_vec[1];
  assign u5_stall = stall_vec[2];

`ifdef FPU_RET_STICKY_EN
  logic [4:0] sticky_q, sticky_d;

  // Clear first, then OR in the word leaving this cycle.
  always_comb begin
    sticky_d = flag_clr ? 5'd0 : sticky_q;
    if (pop) sticky_d = sticky_d | rt.rt_data[4:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 5'd0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = 5'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fpu_ret_merge.sv
`default_nettype none
// Scoreboard bench for fpu_ret_merge: stimulus pushes expected {port,data},
// a negedge monitor pops and compares on every accepted transfer.
module tb_fpu_ret_merge;
`ifdef FPU_RET_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] u1_ret = '0, u3_ret = '0, u5_ret = '0;
  logic        u1_ret_en = 1'b0, u3_ret_en = 1'b0, u5_ret_en = 1'b0;
  logic        u1_stall, u3_stall, u5_stall;
  logic [4:0]  sticky_flags;
  logic        flag_clr = 1'b0;
  logic        ovf_err;

  fpu_ret_merge_if rt_if ();

  fpu_ret_merge #(.DEPTH(4), .STALL_LVL(2)) dut (
    .clk(clk), .rst(rst),
    .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
    .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en),
    .u1_stall(u1_stall), .u3_stall(u3_stall), .u5_stall(u5_stall),
    .rt(rt_if),
    .sticky_flags(sticky_flags), .flag_clr(flag_clr), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rt_if.rt_valid === 1'b1 && rt_if.rt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {rt_if.rt_port, rt_if.rt_data}, 16'hFFFF);
      end else begin
        chk("pop_port_data", {rt_if.rt_port, rt_if.rt_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    flag_clr = 1'b0;
    rt_if.rt_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, rt_if.rt_valid, 1'b0);
    chk({name, "_data"}, rt_if.rt_data, 14'd0);
    chk({name, "_port"}, rt_if.rt_port, 2'd0);
    chk({name, "_stall"}, {u1_stall, u3_stall, u5_stall}, 3'b000);
    chk({name, "_sticky"}, sticky_flags, 5'd0);
    chk({name, "_ovf"}, ovf_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] w [5];
    rt_if.rt_ready = 1'b0;
    #1;
    chk_idle("reset_during");
    tick();
    rst = 1'b0;
    chk_idle("reset_after");

    // Single u1 word with one-cycle latency and flag accumulation.
    rt_if.rt_ready = 1'b1;
    u1_ret = 14'h0A3; u1_ret_en = 1'b1; exp_q.push_back({2'd0, 14'h0A3});
    tick();
    u1_ret_en = 1'b0;
    chk("single_valid", rt_if.rt_valid, 1'b1);
    tick();
    chk("single_empty", rt_if.rt_valid, 1'b0);
    chk("single_sticky", sticky_flags, STICKY_EN ? 5'h03 : 5'h00);
    chk("single_queue", exp_q.size(), 0);

    // All three ports at once pop 0,1,2 on consecutive cycles.
    do_reset();
    rt_if.rt_ready = 1'b1;
    u1_ret = 14'h0101; u3_ret = 14'h0222; u5_ret = 14'h0344;
    u1_ret_en = 1'b1; u3_ret_en = 1'b1; u5_ret_en = 1'b1;
    exp_q.push_back({2'd0, 14'h0101});
    exp_q.push_back({2'd1, 14'h0222});
    exp_q.push_back({2'd2, 14'h0344});
    tick();
    u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    tick(); tick(); tick();
    chk("rr3_queue", exp_q.size(), 0);
    chk("rr3_empty", rt_if.rt_valid, 1'b0);
    chk("rr3_sticky", sticky_flags, STICKY_EN ? 5'h07 : 5'h00);

    // u3 fills, stalls after its second write, fifth write overflows.
    do_reset();
    w[0] = 14'h1100; w[1] = 14'h1101; w[2] = 14'h1102; w[3] = 14'h1103; w[4] = 14'h11FF;
    for (int k = 0; k < 4; k++) begin
      u3_ret = w[k]; u3_ret_en = 1'b1; exp_q.push_back({2'd1, w[k]});
      tick();
      if (k == 0) chk("stall_after_w1", u3_stall, 1'b0);
      if (k == 1) chk("stall_after_w2", u3_stall, 1'b1);
    end
    chk("ovf_before_w5", ovf_err, 1'b0);
    chk("other_stalls", {u1_stall, u5_stall}, 2'b00);
    u3_ret = w[4];
    tick();
    u3_ret_en = 1'b0;
    chk("ovf_after_w5", ovf_err, 1'b1);
    chk("full_port", rt_if.rt_port, 2'd1);
    rt_if.rt_ready = 1'b1;
    drain("ovf_drain", 10);
    tick();
    chk("ovf_drained_empty", rt_if.rt_valid, 1'b0);
    chk("ovf_stall_low", u3_stall, 1'b0);
    chk("ovf_sticks", ovf_err, 1'b1);

    // Full u5 with simultaneous pop and write: nothing is dropped.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      u5_ret = 14'h2200 + 14'(k); u5_ret_en = 1'b1; exp_q.push_back({2'd2, 14'h2200 + 14'(k)});
      tick();
    end
    chk("u5_full_stall", u5_stall, 1'b1);
    u5_ret = 14'h22AA; rt_if.rt_ready = 1'b1; exp_q.push_back({2'd2, 14'h22AA});
    tick();
    u5_ret_en = 1'b0; rt_if.rt_ready = 1'b0;
    chk("full_rw_no_ovf", ovf_err, 1'b0);
    chk("full_rw_occupancy", u5_stall, 1'b1);
    chk("full_rw_remaining", exp_q.size(), 4);
    rt_if.rt_ready = 1'b1;
    drain("full_rw_drain", 10);
    tick();
    chk("full_rw_empty", rt_if.rt_valid, 1'b0);

    // Grant stays on u3 while stalled even though u1 arrives later.
    do_reset();
    u3_ret = 14'h3333; u3_ret_en = 1'b1; exp_q.push_back({2'd1, 14'h3333});
    tick();
    u3_ret_en = 1'b0;
    u1_ret = 14'h0111; u1_ret_en = 1'b1; exp_q.push_back({2'd0, 14'h0111});
    tick();
    u1_ret_en = 1'b0;
    chk("hold_port_a", rt_if.rt_port, 2'd1);
    tick();
    chk("hold_port_b", rt_if.rt_port, 2'd1);
    chk("hold_data", rt_if.rt_data, 14'h3333);
    rt_if.rt_ready = 1'b1;
    drain("hold_drain", 10);

    // Mid-stream reset discards words and restores priority to u1.
    rt_if.rt_ready = 1'b0;
    u3_ret = 14'h3AAA; u5_ret = 14'h3BBB; u3_ret_en = 1'b1; u5_ret_en = 1'b1;
    tick();
    u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    chk("pre_rst_valid", rt_if.rt_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", rt_if.rt_valid, 1'b0);
    tick();
    rst = 1'b0;
    chk_idle("mid_rst_after");
    rt_if.rt_ready = 1'b1;
    u1_ret = 14'h0C01; u3_ret = 14'h0C02; u1_ret_en = 1'b1; u3_ret_en = 1'b1;
    exp_q.push_back({2'd0, 14'h0C01});
    exp_q.push_back({2'd1, 14'h0C02});
    tick();
    u1_ret_en = 1'b0; u3_ret_en = 1'b0;
    drain("post_rst_drain", 10);

    // Clear coincident with a pop keeps only the popped word's flags.
    do_reset();
    rt_if.rt_ready = 1'b1;
    u5_ret = 14'h0010; u5_ret_en = 1'b1; exp_q.push_back({2'd2, 14'h0010});
    tick();
    u5_ret_en = 1'b0;
    tick();
    chk("sticky_10", sticky_flags, STICKY_EN ? 5'h10 : 5'h00);
    u1_ret = 14'h2004; u1_ret_en = 1'b1; exp_q.push_back({2'd0, 14'h2004});
    tick();
    u1_ret_en = 1'b0; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("sticky_clr_pop", sticky_flags, STICKY_EN ? 5'h04 : 5'h00);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("sticky_clr", sticky_flags, 5'h00);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fpu_ret_merge.md
FPU_RET_MERGE -- requirements
Module: fpu_ret_merge

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, per-port retire FIFO depth (power of two, 2..8).
REQ-002 The block SHALL have parameter STALL_LVL, default 2, occupancy at or above which a port's stall is raised.
REQ-003 The block SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports u1_ret, u3_ret, u5_ret  in  14 each  FPU retire word per port: [13:5] retire id, [4:0] exception flags {invalid, divzero, overflow, underflow, inexact}.
REQ-006 The block SHALL have ports u1_ret_en, u3_ret_en, u5_ret_en  in  1 each  retire word valid this cycle.
REQ-007 The block SHALL have ports u1_stall, u3_stall, u5_stall  out  1 each  issue back-pressure per port.
REQ-008 The block SHALL have port rt_valid  out  1  merged retire output valid.
REQ-009 The block SHALL have port rt_ready  in  1  retire unit accepts rt_data this cycle.
REQ-010 The block SHALL have port rt_data  out  14  head retire word of the selected port.
REQ-011 The block SHALL have port rt_port  out  2  source of rt_data: 0=u1, 1=u3, 2=u5.
REQ-012 The block SHALL have port sticky_flags  out  5  accumulated exception flags.
REQ-013 The block SHALL have port flag_clr  in  1  clear sticky_flags.
REQ-014 The block SHALL have port ovf_err  out  1  sticky error: a write was dropped because a FIFO was full.

Function
REQ-015 Each port SHALL own a DEPTH-entry FIFO; uN_ret_en with FIFO not full SHALL write uN_ret at the tail.
REQ-016 uN_ret_en with FIFO full and no same-cycle pop on that port SHALL drop the word and set ovf_err, which holds until reset.
REQ-017 A same-cycle write and pop on a full FIFO SHALL succeed; occupancy is unchanged.
REQ-018 rt_valid SHALL be high when any FIFO is non-empty; rt_data/rt_port SHALL be combinational from the head of the arbitrated port (zero latency from FIFO head).
REQ-019 Arbitration SHALL be round-robin among non-empty FIFOs, starting from the port after the last popped port; after reset priority starts at u1.
REQ-020 A pop SHALL occur only when rt_valid and rt_ready are both high; the grant SHALL not change while rt_valid is high and rt_ready is low.
REQ-021 Minimum write-to-rt_valid latency SHALL be 1 cycle (word written at edge N is visible after edge N).
REQ-022 uN_stall SHALL be registered and high in the cycle after occupancy of that FIFO reaches STALL_LVL or more; low otherwise.
REQ-023 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be held in a counter of width log2(DEPTH)+1.
REQ-024 Flag accumulation per REQ-030; flag_clr coincident with a pop SHALL leave sticky_flags equal to the popped word's flags only (clear then OR).

Reset
REQ-025 On rst all FIFOs SHALL empty, pointers and counters go to 0, arbiter priority go to u1.
REQ-026 During and after reset: rt_valid=0, rt_data=0, rt_port=0, uN_stall=0, sticky_flags=0, ovf_err=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; no pop SHALL be reported in that cycle.
REQ-028 uN_ret_en while rst is high SHALL be ignored.

Configuration
REQ-029 Macro FPU_RET_STICKY_EN SHALL select sticky flag accumulation.
REQ-030 With FPU_RET_STICKY_EN defined, each pop SHALL OR rt_data[4:0] into sticky_flags at the pop edge; flag_clr SHALL zero it.
REQ-031 Without FPU_RET_STICKY_EN, sticky_flags SHALL be constant 0, flag_clr ignored, and no flag registers instantiated.

Verification
REQ-032 Reset, then u1_ret_en=1, u1_ret=14'h0A3 for one cycle, rt_ready=1 -> next cycle rt_valid=1, rt_data=14'h0A3, rt_port=0; cycle after, rt_valid=0, sticky_flags=5'h03.
REQ-033 All three ports write one word same cycle, rt_ready=1 -> pops in order rt_port 0,1,2 on three consecutive cycles.
REQ-034 rt_ready=0, u3 writes 4 words -> u3_stall high from cycle after 2nd write; 5th write sets ovf_err=1 and FIFO still holds first 4 words in order.
REQ-035 u5 FIFO full, rt_ready=1 and u5 write same cycle -> no drop, ovf_err=0, occupancy stays 4.
REQ-036 FIFOs holding words, rst pulsed for 1 cycle mid-stream -> rt_valid=0 and all outputs 0 next cycle; subsequent single write returns on rt_port 0 arbitration start.
REQ-037 sticky_flags=5'h10, flag_clr=1 with pop of flags 5'h04 -> sticky_flags=5'h04; build without FPU_RET_STICKY_EN -> sticky_flags stays 0.
